// File: rtl/seven_seg_scan_mux.sv
// Multiplexed seven-segment scanner. It latches a packed BCD value at frame
// boundaries and walks the digits with blanking and leading-zero suppression.

module seven_seg_lz_cell (
    input  logic [3:0] digit,
    input  logic       upper_zero_in,
    output logic       upper_zero_out
);
    // High when this digit and every digit above it are zero.
    assign upper_zero_out = upper_zero_in && (digit == 4'd0);
endmodule

module seven_seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int LZ_BLANK    = 1,
    localparam int IW = $clog2(NUM_DIGITS),
    localparam int DW = $clog2(REFRESH_DIV)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] BCD_IN,
    input  logic                    load,
    output logic [3:0]              LED_BCD,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);
    logic [DW-1:0]                 div;
    logic [NUM_DIGITS-1:0][3:0]    active;
    logic [NUM_DIGITS-1:0][3:0]    pending;
    logic                          pend_valid;
    logic [NUM_DIGITS:1]           upper_zero;
    logic [NUM_DIGITS-1:0]         suppress;
    logic                          slot_end;
    logic                          blank;

    assign slot_end   = (div == DW'(REFRESH_DIV - 1));
    assign frame_done = slot_end && (digit_idx == IW'(NUM_DIGITS - 1));
    assign blank      = (div < DW'(BLANK_CYC));

    // Zero chain runs from the top digit down; digit 0 always stays lit.
    assign upper_zero[NUM_DIGITS] = 1'b1;
    assign suppress[0]            = 1'b0;

    generate
        for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
            seven_seg_lz_cell u_lz (
                .digit          (active[k]),
                .upper_zero_in  (upper_zero[k+1]),
                .upper_zero_out (upper_zero[k])
            );
            assign suppress[k] = (LZ_BLANK != 0) && upper_zero[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div       <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            div       <= '0;
            digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

    // A load landing on the frame boundary goes straight to active and
    // discards whatever was still pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else if (load && frame_done) begin
            active     <= BCD_IN;
            pend_valid <= 1'b0;
        end else begin
            if (load) begin
                pending    <= BCD_IN;
                pend_valid <= 1'b1;
            end
            if (frame_done && pend_valid) begin
                active     <= pending;
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            LED_BCD <= 4'd0;
            AN      <= '1;
        end else begin
            LED_BCD <= active[digit_idx];
            AN      <= (blank || suppress[digit_idx]) ? '1
                                                      : ~(NUM_DIGITS'(1) << digit_idx);
        end
    end
endmodule
